wb_burst_master: RTL and testbench

//  Wishbone B3 initiator (bus master) that turns single commands into classic or incrementing

---
 rtl/wb_pkg.sv | 28 ++
 rtl/wb_burst_master_if.sv | 31 +++
 rtl/wb_beat_buffer.sv | 41 ++++
 rtl/wb_burst_master.sv | 220 ++++++++++++++++++++++
 tb/tb_wb_burst_master.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_pkg.sv
// Shared definitions for the Wishbone burst master.
//  - Wishbone B3 cycle-type (CTI) and burst-type (BTE) codes
//  - master FSM state encoding
//  - helper that picks the CTI of the next beat
package wb_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;
  localparam logic [1:0] BTE_LINEAR  = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUS   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } wb_state_e;

  // CTI for the beat that follows a completed one inside a multi-beat burst
  function automatic logic [2:0] cti_next(input logic next_is_last);
    if (next_is_last) begin
      return CTI_END;
    end else begin
      return CTI_INCR;
    end
  endfunction

endpackage

// File: rtl/wb_burst_master_if.sv
// Wishbone B3 bus bundle between the burst master and its responder/arbiter.
//  master modport: drives adr/dat/sel/we/cyc/stb/cti/bte, receives dat_i/ack/err
//  slave  modport: the mirror image
interface wb_burst_master_if #(
  parameter int ADR_W = 30,
  parameter int DAT_W = 32
) ();

  logic [ADR_W-1:0]   wb_adr_o;
  logic [DAT_W-1:0]   wb_dat_o;
  logic [DAT_W/8-1:0] wb_sel_o;
  logic               wb_we_o;
  logic               wb_cyc_o;
  logic               wb_stb_o;
  logic [2:0]         wb_cti_o;
  logic [1:0]         wb_bte_o;
  logic [DAT_W-1:0]   wb_dat_i;
  logic               wb_ack_i;
  logic               wb_err_i;

  modport master (
    output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o, wb_cti_o, wb_bte_o,
    input  wb_dat_i, wb_ack_i, wb_err_i
  );

  modport slave (
    input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o, wb_cti_o, wb_bte_o,
    output wb_dat_i, wb_ack_i, wb_err_i
  );

endinterface

// File: rtl/wb_beat_buffer.sv
// One-entry write-data holding register.
//  sys_clk, sys_rst_n : clock, async active-low reset
//  load               : capture wdata and mark full (takes priority over clear)
//  clear              : mark empty (beat retired by ack, or discarded by err)
//  wdata              : incoming write beat
//  full               : entry holds a beat not yet retired
//  data               : held beat, drives the bus data lines directly
module wb_beat_buffer #(
  parameter int DAT_W = 32
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             load,
  input  logic             clear,
  input  logic [DAT_W-1:0] wdata,
  output logic             full,
  output logic [DAT_W-1:0] data
);

  logic             full_r;
  logic [DAT_W-1:0] data_r;

  // Holding register and occupancy flag
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      full_r <= 1'b0;
      data_r <= {DAT_W{1'b0}};
    end else if (load) begin
      full_r <= 1'b1;
      data_r <= wdata;
    end else if (clear) begin
      full_r <= 1'b0;
    end else begin
      full_r <= full_r;
    end
  end

  assign full = full_r;
  assign data = data_r;

endmodule

// File: rtl/wb_burst_master.sv
// Wishbone B3 burst initiator: one command becomes a classic single cycle
// (len=0) or a linear incrementing burst (CTI 010 ... 111, BTE 00).
//  sys_clk, sys_rst_n        : clock, async active-low reset
//  cmd_*                     : command channel, accepted in IDLE on valid&ready
//  wr_valid/wr_ready/wr_data : write beat stream (one-entry buffer)
//  rd_valid/rd_data          : read beat strobe, no backpressure
//  done/done_err             : completion pulse, err qualifies an aborted burst
//  busy                      : state != IDLE
//  wb                        : Wishbone master port, all outputs registered
// Optional build macro WB_MASTER_TIMEOUT_EN: aborts a beat whose stb has been
// high TIMEOUT_CYCLES consecutive cycles without ack/err, exactly like err.
module wb_burst_master
  import wb_pkg::*;
#(
`ifdef WB_MASTER_TIMEOUT_EN
  parameter int TIMEOUT_CYCLES = 255,
`endif
  parameter int ADR_W = 30,
  parameter int DAT_W = 32,
  parameter int LEN_W = 8
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_we,
  input  logic [ADR_W-1:0]   cmd_adr,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [DAT_W/8-1:0] cmd_sel,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [DAT_W-1:0]   wr_data,
  output logic               rd_valid,
  output logic [DAT_W-1:0]   rd_data,
  output logic               done,
  output logic               done_err,
  output logic               busy,
  wb_burst_master_if.master  wb
);

  wb_state_e          state_r;
  logic [ADR_W-1:0]   adr_r;
  // BUS: beats still to complete, minus one (0 = current beat is the last).
  // DRAIN: write beats still to be swallowed.
  logic [LEN_W-1:0]   rem_r;
  logic               we_r;
  logic [DAT_W/8-1:0] sel_r;
  logic               cyc_r;
  logic               stb_r;
  logic [2:0]         cti_r;
  logic               rd_valid_r;
  logic [DAT_W-1:0]   rd_data_r;
  logic               done_r;
  logic               done_err_r;

  logic               buf_full_s;
  logic [DAT_W-1:0]   buf_data_s;
  logic               buf_load_s;
  logic               buf_clear_s;
  logic               timeout_s;
  logic               err_s;
  logic               ack_s;

`ifdef WB_MASTER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt_r;

  // Consecutive stb-high cycles of the current beat without a response
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      to_cnt_r <= {TO_W{1'b0}};
    end else if (!stb_r || wb.wb_ack_i || wb.wb_err_i) begin
      to_cnt_r <= {TO_W{1'b0}};
    end else begin
      to_cnt_r <= to_cnt_r + TO_W'(1);
    end
  end

  // Fires during the TIMEOUT_CYCLES-th unanswered stb cycle
  assign timeout_s = stb_r && (to_cnt_r == TO_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_s = 1'b0;
`endif

  // err beats ack when both arrive; responses while stb is low are ignored
  assign err_s = stb_r && (wb.wb_err_i || timeout_s);
  assign ack_s = stb_r && wb.wb_ack_i && !err_s;

  // In BUS the buffer only accepts while empty; in DRAIN beats bypass it
  assign buf_load_s  = (state_r == ST_BUS) && we_r && !buf_full_s && wr_valid;
  assign buf_clear_s = (state_r == ST_BUS) && we_r && (ack_s || err_s);

  wb_beat_buffer #(.DAT_W(DAT_W)) u_beat_buffer (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .load      (buf_load_s),
    .clear     (buf_clear_s),
    .wdata     (wr_data),
    .full      (buf_full_s),
    .data      (buf_data_s)
  );

  // Burst sequencing FSM with registered bus and status outputs
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_r    <= ST_IDLE;
      adr_r      <= {ADR_W{1'b0}};
      rem_r      <= {LEN_W{1'b0}};
      we_r       <= 1'b0;
      sel_r      <= {(DAT_W/8){1'b0}};
      cyc_r      <= 1'b0;
      stb_r      <= 1'b0;
      cti_r      <= CTI_CLASSIC;
      rd_valid_r <= 1'b0;
      rd_data_r  <= {DAT_W{1'b0}};
      done_r     <= 1'b0;
      done_err_r <= 1'b0;
    end else begin
      rd_valid_r <= 1'b0;
      done_r     <= 1'b0;
      done_err_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (cmd_valid) begin
            state_r <= ST_BUS;
            adr_r   <= cmd_adr;
            rem_r   <= cmd_len;
            we_r    <= cmd_we;
            sel_r   <= cmd_sel;
            cyc_r   <= 1'b1;
            // Writes wait for their first beat before strobing
            stb_r   <= !cmd_we;
            cti_r   <= (cmd_len == {LEN_W{1'b0}}) ? CTI_CLASSIC : CTI_INCR;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_BUS: begin
          if (err_s) begin
            cyc_r <= 1'b0;
            stb_r <= 1'b0;
            cti_r <= CTI_CLASSIC;
            we_r  <= 1'b0;
            if (we_r) begin
              // rem_r already equals the beats the producer has yet to offer
              state_r <= ST_DRAIN;
            end else begin
              state_r    <= ST_DONE;
              done_r     <= 1'b1;
              done_err_r <= 1'b1;
            end
          end else if (ack_s) begin
            adr_r <= adr_r + ADR_W'(1);
            if (!we_r) begin
              rd_valid_r <= 1'b1;
              rd_data_r  <= wb.wb_dat_i;
            end else begin
              rd_data_r  <= rd_data_r;
            end
            if (rem_r == {LEN_W{1'b0}}) begin
              state_r <= ST_DONE;
              cyc_r   <= 1'b0;
              stb_r   <= 1'b0;
              cti_r   <= CTI_CLASSIC;
              we_r    <= 1'b0;
              done_r  <= 1'b1;
            end else begin
              rem_r <= rem_r - LEN_W'(1);
              cti_r <= cti_next(rem_r == LEN_W'(1));
              // Write beat retired: strobe again only once the buffer refills
              stb_r <= !we_r;
            end
          end else if (buf_load_s) begin
            stb_r <= 1'b1;
          end else begin
            stb_r <= stb_r;
          end
        end
        ST_DRAIN: begin
          if (rem_r == {LEN_W{1'b0}}) begin
            state_r    <= ST_DONE;
            done_r     <= 1'b1;
            done_err_r <= 1'b1;
          end else if (wr_valid) begin
            rem_r <= rem_r - LEN_W'(1);
          end else begin
            rem_r <= rem_r;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
          cyc_r   <= 1'b0;
          stb_r   <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready = (state_r == ST_IDLE);
  assign busy      = (state_r != ST_IDLE);
  assign wr_ready  = ((state_r == ST_BUS) && we_r && !buf_full_s) ||
                     ((state_r == ST_DRAIN) && (rem_r != {LEN_W{1'b0}}));
  assign rd_valid  = rd_valid_r;
  assign rd_data   = rd_data_r;
  assign done      = done_r;
  assign done_err  = done_err_r;

  assign wb.wb_adr_o = adr_r;
  assign wb.wb_dat_o = buf_data_s;
  assign wb.wb_sel_o = sel_r;
  assign wb.wb_we_o  = we_r;
  assign wb.wb_cyc_o = cyc_r;
  assign wb.wb_stb_o = stb_r;
  assign wb.wb_cti_o = cti_r;
  assign wb.wb_bte_o = BTE_LINEAR;

endmodule

// File: tb/tb_wb_burst_master.sv
// Bench for wb_burst_master: table of burst commands against a registered-ack
// SRAM-style responder, plus hand sequences for reset and timeout.
module tb_wb_burst_master;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_we = 1'b0;
  logic [29:0] cmd_adr = 30'h0;
  logic [7:0]  cmd_len = 8'h0;
  logic [3:0]  cmd_sel = 4'h0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [31:0] wr_data = 32'h0;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        done;
  logic        done_err;
  logic        busy;

  int n_chk = 0;
  int n_fail = 0;

  wb_burst_master_if #(.ADR_W(30), .DAT_W(32)) bus ();

  wb_burst_master #(
`ifdef WB_MASTER_TIMEOUT_EN
    .TIMEOUT_CYCLES(16),
`endif
    .ADR_W(30), .DAT_W(32), .LEN_W(8)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_adr(cmd_adr), .cmd_len(cmd_len), .cmd_sel(cmd_sel),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .done(done), .done_err(done_err), .busy(busy),
    .wb(bus.master)
  );

  always #5 sys_clk = ~sys_clk;

  // Read data pattern of the responder: a fixed function of the word address
  function automatic logic [31:0] pre(input logic [29:0] a);
    return 32'hC0DE_0000 ^ {2'b00, a};
  endfunction

  function automatic logic [31:0] wdat(input int t, input int i);
    return 32'hDA7A_0000 | (32'(t) << 8) | 32'(i);
  endfunction

  // ---------------- responder: ack registered one cycle after stb, alternating
  int          err_beat = 0;
  logic        err_ack = 1'b0;
  logic        stall = 1'b0;
  logic        s_ack_r, s_err_r;
  logic [31:0] s_dat_r;
  int          s_beat_r;
  logic [31:0] mem [0:1023];

  assign bus.wb_ack_i = s_ack_r;
  assign bus.wb_err_i = s_err_r;
  assign bus.wb_dat_i = s_dat_r;

  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      s_ack_r  <= 1'b0;
      s_err_r  <= 1'b0;
      s_dat_r  <= 32'h0;
      s_beat_r <= 0;
      for (int k = 0; k < 1024; k++) mem[k] <= 32'h0;
    end else begin
      if (bus.wb_cyc_o && bus.wb_stb_o && bus.wb_we_o && s_ack_r && !s_err_r)
        mem[bus.wb_adr_o[9:0]] <= bus.wb_dat_o;
      if (!bus.wb_cyc_o) s_beat_r <= 0;
      else if (s_ack_r && bus.wb_stb_o) s_beat_r <= s_beat_r + 1;
      if (bus.wb_cyc_o && bus.wb_stb_o && !s_ack_r && !s_err_r && !stall) begin
        if (err_beat != 0 && s_beat_r + 1 == err_beat) begin
          s_err_r <= 1'b1;
          s_ack_r <= err_ack;
        end else begin
          s_ack_r <= 1'b1;
        end
        s_dat_r <= pre(bus.wb_adr_o);
      end else begin
        s_ack_r <= 1'b0;
        s_err_r <= 1'b0;
      end
    end
  end

  // ---------------- monitor, sampled mid-cycle
  logic [29:0] beat_adr_q [$];
  logic [2:0]  beat_cti_q [$];
  logic [31:0] rd_q [$];
  logic        done_q [$];
  int          low_q [$];
  int          low_run = 0;
  int          wr_hs = 0;
  int          stb_hi = 0;
  int          term_cnt = 0;
  int          cyc_late = 0;
  logic        term_prev = 1'b0;

  always @(negedge sys_clk) begin
    if (bus.wb_cyc_o && bus.wb_stb_o && bus.wb_ack_i && !bus.wb_err_i) begin
      beat_adr_q.push_back(bus.wb_adr_o);
      beat_cti_q.push_back(bus.wb_cti_o);
    end
    if (rd_valid) rd_q.push_back(rd_data);
    if (done) done_q.push_back(done_err);
    if (wr_valid && wr_ready) wr_hs <= wr_hs + 1;
    if (bus.wb_stb_o) stb_hi <= stb_hi + 1;
    if (bus.wb_cyc_o && !bus.wb_stb_o) begin
      low_run <= low_run + 1;
    end else begin
      if (low_run != 0) low_q.push_back(low_run);
      low_run <= 0;
    end
    term_prev <= bus.wb_stb_o && (bus.wb_err_i || (bus.wb_ack_i &&
                 (bus.wb_cti_o == 3'b000 || bus.wb_cti_o == 3'b111)));
    if (term_prev) begin
      term_cnt <= term_cnt + 1;
      if (bus.wb_cyc_o) cyc_late <= cyc_late + 1;
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [29:0] adr;
    logic [7:0]  len;
    int          err_beat;
    logic        err_ack;
    int          gap_beat;
    int          exp_beats;
    int          exp_rdv;
    int          exp_wr;
    logic        exp_err;
    int          exp_max_low;
  } vec_t;

  vec_t vt [5];

  task automatic run_vec(input int t, input vec_t v);
    int b_beats, b_rdv, b_done, b_low, b_wr, b_late, b_term, guard, to_err, mx, nb;
    logic [29:0] a;
    b_beats = beat_adr_q.size(); b_rdv = rd_q.size(); b_done = done_q.size();
    b_low = low_q.size(); b_wr = wr_hs; b_late = cyc_late; b_term = term_cnt;
    err_beat = v.err_beat; err_ack = v.err_ack;
    to_err = 0;
    @(negedge sys_clk);
    cmd_valid = 1'b1; cmd_we = v.we; cmd_adr = v.adr; cmd_len = v.len; cmd_sel = 4'hF;
    guard = 0;
    while (!cmd_ready && guard < 50) begin @(negedge sys_clk); guard++; end
    @(negedge sys_clk);
    cmd_valid = 1'b0;
    check($sformatf("t%0d busy", t), busy, 1);
    check($sformatf("t%0d cmd_ready", t), cmd_ready, 0);
    if (v.we) begin
      for (int i = 0; i <= int'(v.len); i++) begin
        if (i == v.gap_beat) begin
          guard = 0;
          while (!wr_ready && guard < 100) begin @(negedge sys_clk); guard++; end
          repeat (4) @(negedge sys_clk);
        end
        wr_valid = 1'b1; wr_data = wdat(t, i);
        guard = 0;
        while (!wr_ready && guard < 100) begin @(negedge sys_clk); guard++; end
        if (guard >= 100) to_err++;
        @(negedge sys_clk);
        wr_valid = 1'b0;
      end
      check($sformatf("t%0d wr_feed_timeout", t), 64'(to_err), 0);
    end
    guard = 0;
    while (done_q.size() == b_done && guard < 2000) begin @(negedge sys_clk); guard++; end
    repeat (2) @(negedge sys_clk);
    nb = beat_adr_q.size() - b_beats;
    check($sformatf("t%0d beats", t), 64'(nb), 64'(v.exp_beats));
    for (int i = 0; i < nb && i < v.exp_beats; i++) begin
      a = v.adr + 30'(i);
      check($sformatf("t%0d adr[%0d]", t, i), beat_adr_q[b_beats+i], a);
      check($sformatf("t%0d cti[%0d]", t, i), beat_cti_q[b_beats+i],
            (v.len == 8'd0) ? 3'b000 : ((i == int'(v.len)) ? 3'b111 : 3'b010));
      if (v.we) check($sformatf("t%0d mem[%0d]", t, i), mem[a[9:0]], wdat(t, i));
    end
    check($sformatf("t%0d rd_valid count", t), 64'(rd_q.size() - b_rdv), 64'(v.exp_rdv));
    for (int i = 0; i < rd_q.size() - b_rdv && i < v.exp_rdv; i++)
      check($sformatf("t%0d rd_data[%0d]", t, i), rd_q[b_rdv+i], pre(v.adr + 30'(i)));
    check($sformatf("t%0d done count", t), 64'(done_q.size() - b_done), 1);
    if (done_q.size() > b_done)
      check($sformatf("t%0d done_err", t), done_q[b_done], v.exp_err);
    check($sformatf("t%0d wr beats", t), 64'(wr_hs - b_wr), 64'(v.exp_wr));
    mx = 0;
    for (int i = b_low; i < low_q.size(); i++) if (low_q[i] > mx) mx = low_q[i];
    check($sformatf("t%0d max stb-low run", t), 64'(mx), 64'(v.exp_max_low));
    if (!stall) begin
      check($sformatf("t%0d terminations", t), 64'(term_cnt - b_term), 1);
      check($sformatf("t%0d cyc late", t), 64'(cyc_late - b_late), 0);
    end
    check($sformatf("t%0d idle", t), {busy, cmd_ready, bus.wb_cyc_o}, 3'b010);
  endtask

  initial begin
    int b_stb;
    //           we    adr            len   errb eack  gap beats rdv wr  err  low
    vt[0] = '{1'b0, 30'h0000_0100, 8'd0, 0, 1'b0, -1, 1, 1, 0, 1'b0, 0};
    vt[1] = '{1'b1, 30'h3FFF_FFFE, 8'd3, 0, 1'b0, -1, 4, 0, 4, 1'b0, 1};
    vt[2] = '{1'b1, 30'h0000_0300, 8'd2, 0, 1'b0,  1, 3, 0, 3, 1'b0, 5};
    vt[3] = '{1'b0, 30'h0000_0200, 8'd7, 3, 1'b1, -1, 2, 2, 0, 1'b1, 0};
    vt[4] = '{1'b1, 30'h0000_0340, 8'd4, 1, 1'b0, -1, 0, 0, 5, 1'b1, 1};

    // Reset state
    #1;
    check("reset outputs", {bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.wb_cti_o,
                            done, done_err, rd_valid, wr_ready, busy}, 11'h0);
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    check("cmd_ready after reset", cmd_ready, 1);

    for (int t = 0; t < 5; t++) run_vec(t, vt[t]);

`ifdef WB_MASTER_TIMEOUT_EN
    // Unanswered single read is aborted after 16 strobe cycles
    stall = 1'b1;
    b_stb = stb_hi;
    run_vec(5, '{1'b0, 30'h0000_0010, 8'd0, 0, 1'b0, -1, 0, 0, 0, 1'b1, 0});
    check("timeout stb cycles", 64'(stb_hi - b_stb), 16);
    stall = 1'b0;
`else
    b_stb = 0;
`endif

    // Reset asserted in the middle of a stalled burst
    stall = 1'b1;
    @(negedge sys_clk);
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 30'h180; cmd_len = 8'd7; cmd_sel = 4'hF;
    @(negedge sys_clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge sys_clk);
    check("mid-burst cyc/stb", {bus.wb_cyc_o, bus.wb_stb_o, busy}, 3'b111);
    #2 sys_rst_n = 1'b0;
    #1;
    check("reset mid-burst", {bus.wb_cyc_o, bus.wb_stb_o, done, done_err, rd_valid, busy}, 6'h0);
    stall = 1'b0;
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    check("cmd_ready after mid-burst reset", cmd_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Global guard against a hung run
  initial begin
    #200000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1, "global timeout");
  end

endmodule
